// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN floor-call scheduler issuing one-floor hops to the stepper driver
// Owns current floor, latched calls, travel direction and the door dwell timer.
module elevator_scheduler #(
   parameter int NUM_FLOORS      = 4,
   parameter int STEPS_PER_FLOOR = 11719,
   parameter int DOOR_CYCLES     = 200000000,
   parameter int FW              = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_FLOORS-1:0] call_pulse,
   input  logic                  motor_done,
   output logic                  cmd_start,
   output logic                  cmd_dir,
   output logic [15:0]           cmd_steps,
   output logic [FW-1:0]         cur_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  door_open,
   output logic                  moving
);
   localparam int              DW        = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [DW-1:0]   DOOR_LAST = DW'(DOOR_CYCLES - 1);
   localparam logic [FW-1:0]   TOP_FLOOR = FW'(NUM_FLOORS - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_MOVE, S_DOOR} state_t;

   state_t                r_state, w_state_nxt;
   logic [FW-1:0]         r_floor, w_floor_nxt;
   logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
   logic                  r_dir, w_dir_nxt;
   logic [DW-1:0]         r_timer, w_timer_nxt;

   logic [FW-1:0]         w_hop_floor;
   logic [NUM_FLOORS-1:0] w_calls;
   logic [NUM_FLOORS-1:0] w_here_mask;
   logic [NUM_FLOORS-1:0] w_hop_mask;
   logic                  w_here_call;
   logic                  w_above_cur;
   logic                  w_below_cur;
   logic                  w_hop_hit;
   logic                  w_beyond_hop;

   // Floor reached if the current hop completes; clamped so it never leaves the shaft.
   always_comb begin
      w_hop_floor = r_floor;
      if (r_dir) begin
         if (r_floor != '0) w_hop_floor = r_floor - 1'b1;
      end else begin
         if (r_floor != TOP_FLOOR) w_hop_floor = r_floor + 1'b1;
      end
   end

   assign w_calls = r_pending | call_pulse;

   always_comb begin
      w_here_mask  = '0;
      w_hop_mask   = '0;
      w_here_call  = 1'b0;
      w_above_cur  = 1'b0;
      w_below_cur  = 1'b0;
      w_hop_hit    = 1'b0;
      w_beyond_hop = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (FW'(i) == r_floor) begin
            w_here_mask[i] = 1'b1;
            w_here_call    = call_pulse[i];
         end
         if (FW'(i) == w_hop_floor) begin
            w_hop_mask[i] = 1'b1;
            w_hop_hit     = w_calls[i];
         end
         if (FW'(i) > r_floor) w_above_cur = w_above_cur | r_pending[i];
         if (FW'(i) < r_floor) w_below_cur = w_below_cur | r_pending[i];
         if (r_dir ? (FW'(i) < w_hop_floor) : (FW'(i) > w_hop_floor))
            w_beyond_hop = w_beyond_hop | w_calls[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_floor   <= '0;
         r_pending <= '0;
         r_dir     <= 1'b0;
         r_timer   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_floor   <= w_floor_nxt;
         r_pending <= w_pending_nxt;
         r_dir     <= w_dir_nxt;
         r_timer   <= w_timer_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_floor_nxt   = r_floor;
      w_pending_nxt = w_calls;
      w_dir_nxt     = r_dir;
      w_timer_nxt   = r_timer;
      case (r_state)
         S_IDLE: begin
            // A call at the car's own floor opens the door instead of being latched.
            w_pending_nxt = w_calls & ~w_here_mask;
            if (w_here_call) begin
               w_state_nxt = S_DOOR;
               w_timer_nxt = '0;
            end else if (r_pending != '0) begin
               w_dir_nxt   = r_dir ? w_below_cur : ~w_above_cur;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_state_nxt = S_MOVE;
         end
         S_MOVE: begin
            if (motor_done) begin
               w_floor_nxt = w_hop_floor;
               if (w_hop_hit) begin
                  w_pending_nxt = w_calls & ~w_hop_mask;
                  w_state_nxt   = S_DOOR;
                  w_timer_nxt   = '0;
               end else if (w_beyond_hop) begin
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DOOR: begin
            w_pending_nxt = w_calls & ~w_here_mask;
            if (w_here_call) begin
               w_timer_nxt = '0;
            end else if (r_timer == DOOR_LAST) begin
               w_timer_nxt = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign cmd_start = (r_state == S_START);
   assign moving    = (r_state == S_START) || (r_state == S_MOVE);
   assign door_open = (r_state == S_DOOR);
   assign cmd_dir   = r_dir;
   assign cmd_steps = 16'(STEPS_PER_FLOOR);
   assign cur_floor = r_floor;
   assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - self-checking bench for elevator_scheduler
// Counter-based car model checked every cycle, plus literal scenario expectations.
module tb_elevator_scheduler;
   localparam int NF = 4;
   localparam int DC = 20;
   localparam int SPF = 11719;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NF-1:0] call_pulse;
   logic          motor_done;
   logic          cmd_start, cmd_dir, door_open, moving;
   logic [15:0]   cmd_steps;
   logic [2:0]    cur_floor;
   logic [NF-1:0] pending;

   logic drv_done, spur_done;
   int   drv_cnt;
   int   errors = 0;
   int   checks = 0;

   assign motor_done = drv_done | spur_done;

   elevator_scheduler #(
      .NUM_FLOORS(NF), .STEPS_PER_FLOOR(SPF), .DOOR_CYCLES(DC), .FW(3)
   ) dut (
      .clk(clk), .reset_n(reset_n), .call_pulse(call_pulse), .motor_done(motor_done),
      .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
      .cur_floor(cur_floor), .pending(pending), .door_open(door_open), .moving(moving)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Car model: a hop is "commanded" for one cycle, then in flight until done;
   // the door is a count of open cycles remaining.
   logic [NF-1:0] m_pend;
   int            m_floor, m_door_left;
   bit            m_dir, m_start, m_hop;

   function automatic bit any_beyond(input logic [NF-1:0] p, input int f, input bit down);
      bit r = 1'b0;
      for (int i = 0; i < NF; i++)
         if (p[i] && (down ? (i < f) : (i > f))) r = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_floor = 0; m_door_left = 0; m_dir = 0; m_start = 0; m_hop = 0;
   endtask

   task automatic model_step(input logic [NF-1:0] c, input bit d);
      logic [NF-1:0] calls, old;
      int f;
      old   = m_pend;
      calls = m_pend | c;
      if (m_start) begin
         m_start = 0; m_hop = 1; m_pend = calls;
      end else if (m_hop) begin
         m_pend = calls;
         if (d) begin
            f = m_dir ? m_floor - 1 : m_floor + 1;
            if (f < 0) f = 0;
            if (f > NF - 1) f = NF - 1;
            m_floor = f;
            m_hop   = 0;
            if (calls[f]) begin
               m_pend[f]   = 1'b0;
               m_door_left = DC;
            end else if (any_beyond(calls, f, m_dir)) begin
               m_start = 1;
            end
         end
      end else if (m_door_left > 0) begin
         m_pend = calls; m_pend[m_floor] = 1'b0;
         if (c[m_floor]) m_door_left = DC;
         else m_door_left--;
      end else begin
         m_pend = calls; m_pend[m_floor] = 1'b0;
         if (c[m_floor]) m_door_left = DC;
         else if (old != '0) begin
            if (!any_beyond(old, m_floor, m_dir)) m_dir = !m_dir;
            m_start = 1;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step(call_pulse, motor_done);
      end
   end

   // Per-cycle output comparison against the model.
   initial begin
      logic [10:0] act, exp;
      forever begin
         @(negedge clk);
         act = {cmd_start, cmd_dir, cur_floor, pending, door_open, moving};
         exp = {m_start, m_dir, 3'(m_floor), m_pend, (m_door_left > 0), (m_start || m_hop)};
         chk("outputs_vs_model", int'(act), int'(exp));
      end
   end

   // Driver model: motor_done ten cycles after cmd_start.
   initial begin
      drv_done = 1'b0; drv_cnt = 0;
      forever begin
         @(posedge clk); #1;
         drv_done = 1'b0;
         if (drv_cnt > 0) begin
            drv_cnt--;
            if (drv_cnt == 0) drv_done = 1'b1;
         end
         if (cmd_start) drv_cnt = 10;
      end
   end

   // Event monitor for literal scenario checks.
   int q_start_dir[$];
   int q_start_floor[$];
   int q_door_floor[$];
   int q_door_pend[$];
   int mon_door_cyc;
   bit mon_prev_door = 1'b0;
   initial begin
      mon_door_cyc = 0;
      forever begin
         @(negedge clk);
         if (cmd_start) begin
            q_start_dir.push_back(int'(cmd_dir));
            q_start_floor.push_back(int'(cur_floor));
         end
         if (door_open) mon_door_cyc++;
         if (door_open && !mon_prev_door) begin
            q_door_floor.push_back(int'(cur_floor));
            q_door_pend.push_back(int'(pending));
         end
         mon_prev_door = door_open;
      end
   end

   task automatic mon_clear();
      q_start_dir.delete(); q_start_floor.delete();
      q_door_floor.delete(); q_door_pend.delete();
      mon_door_cyc = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse(input int f);
      call_pulse[f] = 1'b1;
      cycles(1);
      call_pulse = '0;
   endtask

   task automatic pulse_mask(input logic [NF-1:0] m);
      call_pulse = m;
      cycles(1);
      call_pulse = '0;
   endtask

   task automatic run_until_idle(input string name, input int budget);
      int n = 0;
      do begin
         cycles(1);
         n++;
      end while (!(!moving && !door_open && pending == '0) && n < budget);
      if (n >= budget) chk({name, "_timeout"}, n, 0);
      cycles(1);
   endtask

   initial begin
      reset_n = 1'b0; call_pulse = '0; spur_done = 1'b0;
      cycles(3);
      reset_n = 1'b1;
      cycles(1);
      chk("rst_cur_floor", int'(cur_floor), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_door", int'(door_open), 0);
      chk("rst_moving", int'(moving), 0);
      chk("rst_cmd_steps", int'(cmd_steps), SPF);

      // Two-floor trip 0 -> 2
      mon_clear();
      pulse(2);
      chk("trip_pending_latched", int'(pending), 4'b0100);
      chk("trip_no_start_yet", int'(cmd_start), 0);
      cycles(1);
      chk("trip_start_latency", int'(cmd_start), 1);
      run_until_idle("trip", 300);
      chk("trip_starts", q_start_dir.size(), 2);
      if (q_start_floor.size() == 2) begin
         chk("trip_dir0", q_start_dir[0], 0);
         chk("trip_dir1", q_start_dir[1], 0);
         chk("trip_hop2_from", q_start_floor[1], 1);
      end
      chk("trip_door_cycles", mon_door_cyc, DC);
      chk("trip_floor", int'(cur_floor), 2);
      chk("trip_pending_clear", int'(pending), 0);

      // Return home, then intermediate stop 0 -> (1) -> 3
      pulse(0);
      run_until_idle("home", 300);
      chk("home_floor", int'(cur_floor), 0);
      mon_clear();
      pulse(3);
      cycles(5);
      pulse(1);
      run_until_idle("inter", 400);
      chk("inter_starts", q_start_dir.size(), 3);
      chk("inter_doors", q_door_floor.size(), 2);
      if (q_door_floor.size() == 2) begin
         chk("inter_door0_floor", q_door_floor[0], 1);
         chk("inter_door0_pend", q_door_pend[0], 4'b1000);
         chk("inter_door1_floor", q_door_floor[1], 3);
         chk("inter_door1_pend", q_door_pend[1], 0);
      end
      chk("inter_door_cycles", mon_door_cyc, 2 * DC);

      // SCAN order: get to floor 2 heading up, then call 0 and 3 together
      pulse(0);
      run_until_idle("scan_pre0", 400);
      pulse(2);
      run_until_idle("scan_pre2", 400);
      chk("scan_pre_floor", int'(cur_floor), 2);
      mon_clear();
      pulse_mask(4'b1001);
      run_until_idle("scan", 600);
      chk("scan_starts", q_start_dir.size(), 4);
      if (q_start_dir.size() == 4) begin
         chk("scan_dir_up", q_start_dir[0], 0);
         chk("scan_dir_dn1", q_start_dir[1], 1);
         chk("scan_dir_dn3", q_start_dir[3], 1);
      end
      if (q_door_floor.size() == 2) begin
         chk("scan_door_first", q_door_floor[0], 3);
         chk("scan_door_second", q_door_floor[1], 0);
      end else chk("scan_doors", q_door_floor.size(), 2);

      // Same-floor call at floor 1 with re-pulse at timer 15
      pulse(1);
      run_until_idle("to1", 300);
      mon_clear();
      pulse(1);
      chk("same_door_open", int'(door_open), 1);
      chk("same_pending", int'(pending), 0);
      cycles(15);
      chk("same_still_open", int'(door_open), 1);
      pulse(1);
      run_until_idle("same", 100);
      chk("same_door_cycles", mon_door_cyc, 16 + DC);
      chk("same_no_start", q_start_dir.size(), 0);
      chk("same_door_runs", q_door_floor.size(), 1);

      // Spurious done in IDLE
      spur_done = 1'b1;
      cycles(1);
      spur_done = 1'b0;
      cycles(1);
      chk("spur_floor", int'(cur_floor), 1);
      chk("spur_moving", int'(moving), 0);

      // Reset mid-hop; the late done must be ignored
      pulse(3);
      begin
         int n = 0;
         while (!cmd_start && n < 20) begin cycles(1); n++; end
         chk("mid_start_seen", int'(cmd_start), 1);
      end
      cycles(3);
      chk("mid_moving", int'(moving), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_moving", int'(moving), 0);
      chk("async_floor", int'(cur_floor), 0);
      chk("async_pending", int'(pending), 0);
      chk("async_start", int'(cmd_start), 0);
      chk("async_door", int'(door_open), 0);
      chk("async_dir", int'(cmd_dir), 0);
      chk("async_steps", int'(cmd_steps), SPF);
      @(posedge clk); #1;
      cycles(1);
      reset_n = 1'b1;
      cycles(12);
      chk("late_done_floor", int'(cur_floor), 0);
      chk("late_done_moving", int'(moving), 0);
      chk("late_done_pending", int'(pending), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
